// File: rtl/bomber_pkg.sv
// Shared types and geometry constants for the player movers and renderers.
package bomber_pkg;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam int unsigned TILE_SHIFT  = 5;
  localparam int unsigned SPRITE_SIZE = 32;
  localparam int unsigned HACTIVE     = 800;
  localparam int unsigned VACTIVE     = 600;
  localparam int unsigned SPRITE_MAX  = 6;

endpackage

// File: rtl/corner_calc.sv
// Maps a move direction and target box origin to the tile coordinates of the
// two leading corners that must be free for the move to be legal.
module corner_calc
  import bomber_pkg::*;
(
  input  dir_t              dir,
  input  logic signed [10:0] tx,
  input  logic signed [10:0] ty,
  output logic [4:0]        col_a,
  output logic [4:0]        row_a,
  output logic [4:0]        col_b,
  output logic [4:0]        row_b
);

  localparam logic signed [10:0] FarOff = 11'(SPRITE_SIZE - 1);

  logic signed [10:0] ax, ay, bx, by;

  always_comb begin
    ax = tx;
    ay = ty;
    bx = tx + FarOff;
    by = ty + FarOff;
    unique case (dir)
      DIR_UP:    by = ty;
      DIR_DOWN:  ay = ty + FarOff;
      DIR_LEFT:  bx = tx;
      DIR_RIGHT: ax = tx + FarOff;
      default:   ;
    endcase
    // Sums stay 11-bit; only in-bounds targets reach the map so they are non-negative.
    col_a = 5'(ax >>> TILE_SHIFT);
    row_a = 5'(ay >>> TILE_SHIFT);
    col_b = 5'(bx >>> TILE_SHIFT);
    row_b = 5'(by >>> TILE_SHIFT);
  end

endmodule

// File: rtl/player2_move.sv
// Per-frame position/animation controller for player 2: on each frame tick it
// probes the tile map at the two leading corners and commits or holds the move.
module player2_move #(
  parameter int          INIT_X   = 32,
  parameter int          INIT_Y   = 32,
  parameter int          STEP     = 2,
  parameter int unsigned ANIM_DIV = 4,
  parameter int          HACTIVE  = 800,
  parameter int          VACTIVE  = 600
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic [4:0]         map_col,
  output logic [4:0]         map_row,
  input  logic               map_solid,
  output logic signed [10:0] centerX2,
  output logic signed [10:0] centerY2,
  output logic [2:0]         sprite_num,
  output logic               busy
);

  import bomber_pkg::*;

  localparam logic signed [10:0] InitX = 11'(INIT_X);
  localparam logic signed [10:0] InitY = 11'(INIT_Y);
  localparam logic signed [10:0] StepS = 11'(STEP);
  localparam logic signed [10:0] MaxX  = 11'(HACTIVE - int'(SPRITE_SIZE));
  localparam logic signed [10:0] MaxY  = 11'(VACTIVE - int'(SPRITE_SIZE));
  localparam int unsigned        AnimW = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AnimW-1:0]   AnimLast = AnimW'(ANIM_DIV - 1);

  typedef enum logic [2:0] {StIdle, StReqA, StReqB, StWaitB, StCommit} state_e;

  state_e             state_q, state_d;
  dir_t               dir_q, dir_req, cc_dir;
  logic signed [10:0] x_q, y_q, x_d, y_d;
  logic signed [10:0] tx_q, ty_q, tx_req, ty_req, cc_tx, cc_ty;
  logic               blocked_q, blocked_req;
  logic               solid_a_q, solid_b_q;
  logic [4:0]         col_q, row_q, col_d, row_d;
  logic [4:0]         col_a, row_a, col_b, row_b;
  logic [AnimW-1:0]   anim_q, anim_d;
  logic [2:0]         sprite_q, sprite_d;
  logic               start, moved;

  assign start = (state_q == StIdle) && frame_tick;

  // Button priority up > down > left > right; one axis per frame.
  always_comb begin
    dir_req = DIR_NONE;
    tx_req  = x_q;
    ty_req  = y_q;
    if (btn_up) begin
      dir_req = DIR_UP;
      ty_req  = y_q - StepS;
    end else if (btn_down) begin
      dir_req = DIR_DOWN;
      ty_req  = y_q + StepS;
    end else if (btn_left) begin
      dir_req = DIR_LEFT;
      tx_req  = x_q - StepS;
    end else if (btn_right) begin
      dir_req = DIR_RIGHT;
      tx_req  = x_q + StepS;
    end
    blocked_req = (tx_req < 11'sd0) || (tx_req > MaxX) || (ty_req < 11'sd0) || (ty_req > MaxY);
  end

  // In IDLE the live request drives the corner lookup so corner A is ready on entry to REQ_A.
  assign cc_dir = (state_q == StIdle) ? dir_req : dir_q;
  assign cc_tx  = (state_q == StIdle) ? tx_req  : tx_q;
  assign cc_ty  = (state_q == StIdle) ? ty_req  : ty_q;

  corner_calc u_corner_calc (
    .dir   (cc_dir),
    .tx    (cc_tx),
    .ty    (cc_ty),
    .col_a (col_a),
    .row_a (row_a),
    .col_b (col_b),
    .row_b (row_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (dir_req == DIR_NONE || blocked_req) ? StCommit : StReqA;
        end
      end
      StReqA:   state_d = StReqB;
      StReqB:   state_d = StWaitB;
      StWaitB:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start && dir_req != DIR_NONE && !blocked_req) begin
      col_d = col_a;
      row_d = row_a;
    end else if (state_q == StReqA) begin
      col_d = col_b;
      row_d = row_b;
    end
  end

  assign moved = (state_q == StCommit) && (dir_q != DIR_NONE) && !blocked_q &&
                 !solid_a_q && !solid_b_q;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    anim_d   = anim_q;
    sprite_d = sprite_q;
    if (state_q == StCommit) begin
      if (moved) begin
        x_d = tx_q;
        y_d = ty_q;
        if (anim_q == AnimLast) begin
          anim_d   = '0;
          sprite_d = (sprite_q >= 3'(SPRITE_MAX)) ? 3'd1 : sprite_q + 3'd1;
        end else begin
          anim_d = anim_q + AnimW'(1);
        end
      end else begin
        anim_d   = '0;
        sprite_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q     <= DIR_NONE;
      tx_q      <= InitX;
      ty_q      <= InitY;
      blocked_q <= 1'b0;
      solid_a_q <= 1'b0;
      solid_b_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      x_q       <= InitX;
      y_q       <= InitY;
      anim_q    <= '0;
      sprite_q  <= '0;
    end else begin
      if (start) begin
        dir_q     <= dir_req;
        tx_q      <= tx_req;
        ty_q      <= ty_req;
        blocked_q <= blocked_req;
        solid_a_q <= 1'b0;
        solid_b_q <= 1'b0;
      end
      // Map read data lags the address by one cycle.
      if (state_q == StReqB) solid_a_q <= map_solid;
      if (state_q == StWaitB) solid_b_q <= map_solid;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      anim_q   <= anim_d;
      sprite_q <= sprite_d;
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    map_col    = col_q;
    map_row    = row_q;
    centerX2   = x_q;
    centerY2   = y_q;
    sprite_num = sprite_q;
  end

endmodule
